// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer (5-8 data bits, optional parity, one stop bit)
// feeding an RX FIFO with per-entry parity/framing/break flags, trigger and timeout status.
module uart_rx #(
    parameter int FifoDepth = 16,
    parameter int OvsRate   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ovs_edge_i,
    input  logic                         rxd_i,
    input  logic [1:0]                   word_len_i,
    input  logic                         par_en_i,
    input  logic [1:0]                   par_sel_i,
    input  logic                         fifo_en_i,
    input  logic                         fifo_rst_i,
    input  logic [1:0]                   rx_trig_i,
    input  logic                         pop_i,
    output logic [7:0]                   rx_data_o,
    output logic                         rx_par_err_o,
    output logic                         rx_frame_err_o,
    output logic                         rx_break_o,
    output logic                         data_ready_o,
    output logic                         fifo_err_o,
    output logic                         overrun_o,
    input  logic                         clr_overrun_i,
    output logic                         trig_o,
    output logic                         timeout_o,
    output logic [$clog2(FifoDepth):0]   usage_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam logic [3:0] MidTick  = 4'(OvsRate / 2 - 1);
    localparam logic [3:0] LastTick = 4'(OvsRate - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI} state_e;

    logic            rx_s1_q, rx_s2_q;
    state_e          state_q;
    logic [3:0]      tick_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            par_bit_q, par_err_q;
    logic            push_q;
    logic [10:0]     entry_q;

    logic [10:0]     mem_q [FifoDepth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overrun_q;
    logic [9:0]      tmo_cnt_q;

    logic [2:0]      last_bit;
    logic            par_exp, brk;
    logic [CntW-1:0] cap;
    logic            full, wr_en, drop, pop_en, empty;
    logic [3:0]      nb_sum;
    logic [9:0]      tmo_thr;
    logic [4:0]      trig_lvl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd_i;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign last_bit = 3'(word_len_i) + 3'd4;

    always_comb begin
        case (par_sel_i)
            2'b00:   par_exp = ~^shift_q;
            2'b01:   par_exp = ^shift_q;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // A break is an all-zero character including parity (when present) and stop.
    assign brk = ~rx_s2_q & (shift_q == 8'h00) & (~par_en_i | ~par_bit_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            tick_q    <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            push_q    <= 1'b0;
            entry_q   <= 11'd0;
        end else begin
            push_q <= 1'b0;
            if (ovs_edge_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s2_q) begin
                            state_q <= S_START;
                            tick_q  <= 4'd0;
                        end
                    end
                    S_START: begin
                        if (tick_q == MidTick) begin
                            if (rx_s2_q) begin
                                state_q <= S_IDLE;
                            end else begin
                                state_q   <= S_DATA;
                                tick_q    <= 4'd0;
                                bit_idx_q <= 3'd0;
                                shift_q   <= 8'h00;
                                par_bit_q <= 1'b0;
                                par_err_q <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (tick_q == LastTick) begin
                            tick_q             <= 4'd0;
                            shift_q[bit_idx_q] <= rx_s2_q;
                            if (bit_idx_q == last_bit) state_q <= par_en_i ? S_PAR : S_STOP;
                            else bit_idx_q <= bit_idx_q + 3'd1;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                    S_PAR: begin
                        if (tick_q == LastTick) begin
                            tick_q    <= 4'd0;
                            par_bit_q <= rx_s2_q;
                            par_err_q <= rx_s2_q != par_exp;
                            state_q   <= S_STOP;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (tick_q == LastTick) begin
                            tick_q  <= 4'd0;
                            push_q  <= 1'b1;
                            entry_q <= {brk, ~rx_s2_q, par_err_q, shift_q};
                            state_q <= rx_s2_q ? S_IDLE : S_WAIT_HI;
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                    S_WAIT_HI: begin
                        // Hold off until the line goes idle so a long break yields one entry.
                        if (rx_s2_q) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign cap    = fifo_en_i ? CntW'(FifoDepth) : CntW'(1);
    assign empty  = (count_q == '0);
    assign full   = (count_q >= cap);
    assign wr_en  = push_q & ~full & ~fifo_rst_i;
    assign drop   = push_q & full & ~fifo_rst_i;
    assign pop_en = pop_i & ~empty & ~fifo_rst_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (fifo_rst_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
                count_q <= count_q + CntW'(wr_en) - CntW'(pop_en);
            end
            if (drop)               overrun_q <= 1'b1;
            else if (clr_overrun_i) overrun_q <= 1'b0;
        end
    end

    assign nb_sum  = 4'd7 + 4'(word_len_i) + 4'(par_en_i);
    assign tmo_thr = {nb_sum, 6'd0};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 10'd0;
        end else if (fifo_rst_i || push_q || pop_en || empty) begin
            tmo_cnt_q <= 10'd0;
        end else if (ovs_edge_i && tmo_cnt_q != 10'h3FF) begin
            tmo_cnt_q <= tmo_cnt_q + 10'd1;
        end
    end

    always_comb begin
        case (rx_trig_i)
            2'b00:   trig_lvl = 5'd1;
            2'b01:   trig_lvl = 5'd4;
            2'b10:   trig_lvl = 5'd8;
            default: trig_lvl = 5'd14;
        endcase
    end

    always_comb begin
        fifo_err_o = 1'b0;
        for (int i = 0; i < FifoDepth; i++) begin
            if ({1'b0, PtrW'(PtrW'(i) - rd_ptr_q)} < count_q && |mem_q[i][10:8])
                fifo_err_o = 1'b1;
        end
    end

    assign data_ready_o   = ~empty;
    assign rx_data_o      = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
    assign rx_par_err_o   = ~empty & mem_q[rd_ptr_q][8];
    assign rx_frame_err_o = ~empty & mem_q[rd_ptr_q][9];
    assign rx_break_o     = ~empty & mem_q[rd_ptr_q][10];
    assign overrun_o      = overrun_q;
    assign usage_o        = count_q;
    assign trig_o         = fifo_en_i ? (32'(count_q) >= 32'(trig_lvl)) : ~empty;
    assign timeout_o      = fifo_en_i & (tmo_cnt_q >= tmo_thr);
endmodule
